// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
//   pipe_stall_t   : stall code driven to every pipeline latch enable
//   hazard_state_t : sequencer state (run, data-cache wait, halt drain, halted)
//   loadUse()      : load-use hazard detect between the EX load and the ID operands
package pipe_hazard_ctrl_pkg;

  typedef enum logic [2:0] {
    NO_STALL   = 3'd0,
    IFID_STALL = 3'd1,
    IDEX_STALL = 3'd2,
    FULL_STALL = 3'd3
  } pipe_stall_t;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_DWAIT,
    HZ_DRAIN,
    HZ_HALTED
  } hazard_state_t;

  // A load targeting $zero never produces a usable value, so it cannot create a hazard.
  function automatic logic loadUse(input logic       exDataRead,
                                   input logic [4:0] exRt,
                                   input logic [4:0] idRs,
                                   input logic [4:0] idRt);
    return exDataRead && (exRt != 5'd0) && ((exRt == idRs) || (exRt == idRt));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
//   clk   : clock
//   rst   : synchronous active-high clear
//   inc   : count this cycle
//   count : current value, sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline latches. Each cycle it picks the
// stall code, the IF/ID and ID/EX flushes and the PC enable from load-use
// hazards, cache waits, EX-resolved redirects and the halt drain, and keeps
// saturating stall/flush performance counters.
//   CLK, RST          : clock, synchronous active-high reset
//   ihit, dhit        : icache / dcache completion this cycle
//   id_rs, id_rt      : operand registers of the instruction in ID
//   ex_DataRead, ex_rt: load in EX and its destination
//   mem_access        : MEM-stage instruction accesses the dcache
//   ex_redirect       : taken branch / jump resolved in EX
//   mem_Halt, wb_Halt : halt marker in MEM / WB
//   stall             : pipe_stall_t code
//   flush_ifid/idex   : load bubble into that latch on the next edge
//   pc_en             : PC may update
//   halt              : sticky CPU halt
//   stall_cnt         : cycles stalled (halted cycles excluded)
//   flush_cnt         : redirect flushes taken
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_DataRead,
  input  logic [4:0]       ex_rt,
  input  logic             mem_access,
  input  logic             ex_redirect,
  input  logic             mem_Halt,
  input  logic             wb_Halt,
  output pipe_stall_t      stall,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             pc_en,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hazard_state_t state, nxtState;
  logic          redirectTaken;
  logic          incStall;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= HZ_RUN;
    end else begin
      state <= nxtState;
    end
  end

  always_comb begin
    nxtState      = state;
    stall         = NO_STALL;
    pc_en         = 1'b1;
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;
    halt          = 1'b0;
    redirectTaken = 1'b0;
    case (state)
      HZ_RUN: begin
        if (mem_access && !dhit) begin
          stall    = FULL_STALL;
          pc_en    = 1'b0;
          nxtState = HZ_DWAIT;
        end else if (mem_Halt) begin
          stall      = IDEX_STALL;
          pc_en      = 1'b0;
          flush_ifid = 1'b1;
          nxtState   = HZ_DRAIN;
        end else if (ex_redirect) begin
          // Redirect outranks load-use: the dependent instruction is squashed anyway.
          flush_ifid    = 1'b1;
          flush_idex    = 1'b1;
          redirectTaken = 1'b1;
        end else if (loadUse(ex_DataRead, ex_rt, id_rs, id_rt) || !ihit) begin
          // Both cases share one code, so a coincident icache miss costs no extra count.
          stall = IFID_STALL;
          pc_en = 1'b0;
        end
      end
      HZ_DWAIT: begin
        // Release in the dhit cycle itself; a frozen EX redirect is picked up in RUN next cycle.
        if (!dhit) begin
          stall = FULL_STALL;
          pc_en = 1'b0;
        end else begin
          nxtState = HZ_RUN;
        end
      end
      HZ_DRAIN: begin
        stall      = IDEX_STALL;
        pc_en      = 1'b0;
        flush_ifid = 1'b1;
        if (wb_Halt) begin
          nxtState = HZ_HALTED;
        end
      end
      HZ_HALTED: begin
        halt  = 1'b1;
        stall = FULL_STALL;
        pc_en = 1'b0;
      end
      default: nxtState = HZ_RUN;
    endcase

    // While in reset every latch holds a bubble and nothing advances.
    if (RST) begin
      nxtState      = HZ_RUN;
      stall         = FULL_STALL;
      pc_en         = 1'b0;
      flush_ifid    = 1'b1;
      flush_idex    = 1'b1;
      halt          = 1'b0;
      redirectTaken = 1'b0;
    end
  end

  assign incStall = (stall != NO_STALL) && (state != HZ_HALTED) && !RST;

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (incStall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (redirectTaken),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST, ihit, dhit, ex_DataRead, mem_access, ex_redirect, mem_Halt, wb_Halt;
  logic [4:0] id_rs, id_rt, ex_rt;

  pipe_stall_t stall, stallS;
  logic        flush_ifid, flush_idex, pc_en, halt;
  logic        flushIfidS, flushIdexS, pcEnS, haltS;
  logic [31:0] stall_cnt, flush_cnt;
  logic [1:0]  stallCntS, flushCntS;

  pipe_hazard_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .id_rs(id_rs), .id_rt(id_rt),
    .ex_DataRead(ex_DataRead), .ex_rt(ex_rt), .mem_access(mem_access),
    .ex_redirect(ex_redirect), .mem_Halt(mem_Halt), .wb_Halt(wb_Halt),
    .stall(stall), .flush_ifid(flush_ifid), .flush_idex(flush_idex), .pc_en(pc_en),
    .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter copy driven identically, to exercise saturation.
  pipe_hazard_ctrl #(.CNT_W(2)) dutSat (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .id_rs(id_rs), .id_rt(id_rt),
    .ex_DataRead(ex_DataRead), .ex_rt(ex_rt), .mem_access(mem_access),
    .ex_redirect(ex_redirect), .mem_Halt(mem_Halt), .wb_Halt(wb_Halt),
    .stall(stallS), .flush_ifid(flushIfidS), .flush_idex(flushIdexS), .pc_en(pcEnS),
    .halt(haltS), .stall_cnt(stallCntS), .flush_cnt(flushCntS)
  );

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic checkOut(input string tag, input pipe_stall_t s, input logic pc,
                          input logic fi, input logic fx);
    check({tag, ".stall"}, 32'(stall), 32'(s));
    check({tag, ".pc_en"}, 32'(pc_en), 32'(pc));
    check({tag, ".flush_ifid"}, 32'(flush_ifid), 32'(fi));
    check({tag, ".flush_idex"}, 32'(flush_idex), 32'(fx));
  endtask

  task automatic idle();
    RST = 1'b0; ihit = 1'b1; dhit = 1'b0; ex_DataRead = 1'b0; mem_access = 1'b0;
    ex_redirect = 1'b0; mem_Halt = 1'b0; wb_Halt = 1'b0;
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
  endtask

  // Inputs change just after posedge; outputs are sampled at negedge.
  task automatic toSample();
    @(negedge CLK);
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    idle();
    RST = 1'b1;
    // Reset held two cycles
    for (int i = 0; i < 2; i++) begin
      toSample();
      checkOut("rst", FULL_STALL, 1'b0, 1'b1, 1'b1);
      check("rst.halt", 32'(halt), 32'd0);
      nextCycle();
    end

    idle();
    toSample();
    checkOut("idle", NO_STALL, 1'b1, 1'b0, 1'b0);
    check("idle.stall_cnt", stall_cnt, 32'd0);
    check("idle.flush_cnt", flush_cnt, 32'd0);
    check("idle.halt", 32'(halt), 32'd0);
    nextCycle();

    // Load-use on rs
    ex_DataRead = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    toSample();
    checkOut("luRs", IFID_STALL, 1'b0, 1'b0, 1'b0);
    nextCycle();
    idle();
    toSample();
    checkOut("luAfter", NO_STALL, 1'b1, 1'b0, 1'b0);
    check("luAfter.stall_cnt", stall_cnt, 32'd1);
    nextCycle();

    // Load into $zero is not a hazard
    ex_DataRead = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    toSample();
    checkOut("luZero", NO_STALL, 1'b1, 1'b0, 1'b0);
    nextCycle();

    // Load-use on rt coinciding with icache miss: one stall cycle, one count
    ex_DataRead = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd3; ihit = 1'b0;
    toSample();
    checkOut("luRtMiss", IFID_STALL, 1'b0, 1'b0, 1'b0);
    nextCycle();

    // Plain icache miss
    idle(); ihit = 1'b0;
    toSample();
    checkOut("imiss", IFID_STALL, 1'b0, 1'b0, 1'b0);
    check("imiss.stall_cnt", stall_cnt, 32'd2);
    nextCycle();

    // Dcache wait for three cycles
    idle(); mem_access = 1'b1;
    for (int i = 0; i < 3; i++) begin
      toSample();
      checkOut("dwait", FULL_STALL, 1'b0, 1'b0, 1'b0);
      if (i == 0) check("dwait.stall_cnt", stall_cnt, 32'd3);
      nextCycle();
    end
    dhit = 1'b1;
    toSample();
    checkOut("dhit", NO_STALL, 1'b1, 1'b0, 1'b0);
    check("dhit.stall_cnt", stall_cnt, 32'd6);
    nextCycle();
    idle();
    toSample();
    check("afterD.stall_cnt", stall_cnt, 32'd6);
    check("sat.stall_cnt", 32'(stallCntS), 32'd3);
    nextCycle();

    // Redirect outranks load-use
    ex_redirect = 1'b1; ex_DataRead = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    toSample();
    checkOut("redir", NO_STALL, 1'b1, 1'b1, 1'b1);
    nextCycle();
    idle();
    toSample();
    check("redir.flush_cnt", flush_cnt, 32'd1);
    check("redir.stall_cnt", stall_cnt, 32'd6);
    nextCycle();

    // Redirect frozen across a two-cycle dcache wait
    mem_access = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 2; i++) begin
      toSample();
      checkOut("dwRedir", FULL_STALL, 1'b0, 1'b0, 1'b0);
      nextCycle();
    end
    dhit = 1'b1;
    toSample();
    checkOut("dwRel", NO_STALL, 1'b1, 1'b0, 1'b0);
    nextCycle();
    idle(); ex_redirect = 1'b1;
    toSample();
    checkOut("dwFlush", NO_STALL, 1'b1, 1'b1, 1'b1);
    nextCycle();
    idle();
    toSample();
    check("dwFlush.flush_cnt", flush_cnt, 32'd2);
    check("dwFlush.stall_cnt", stall_cnt, 32'd8);
    check("sat.flush_cnt", 32'(flushCntS), 32'd2);
    nextCycle();

    // Halt drain
    mem_Halt = 1'b1;
    toSample();
    checkOut("memHalt", IDEX_STALL, 1'b0, 1'b1, 1'b0);
    nextCycle();
    idle(); wb_Halt = 1'b1;
    toSample();
    checkOut("drain", IDEX_STALL, 1'b0, 1'b1, 1'b0);
    check("drain.halt", 32'(halt), 32'd0);
    nextCycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      ex_redirect = 1'b1; mem_access = (i == 1);
      toSample();
      checkOut("halted", FULL_STALL, 1'b0, 1'b0, 1'b0);
      check("halted.halt", 32'(halt), 32'd1);
      check("halted.stall_cnt", stall_cnt, 32'd10);
      check("halted.flush_cnt", flush_cnt, 32'd2);
      nextCycle();
    end

    // Reset out of HALTED
    idle(); RST = 1'b1;
    toSample();
    checkOut("rstHalt", FULL_STALL, 1'b0, 1'b1, 1'b1);
    nextCycle();
    idle();
    toSample();
    checkOut("postRst", NO_STALL, 1'b1, 1'b0, 1'b0);
    check("postRst.halt", 32'(halt), 32'd0);
    check("postRst.stall_cnt", stall_cnt, 32'd0);
    check("postRst.flush_cnt", flush_cnt, 32'd0);
    nextCycle();

    // Reset in the middle of a dcache wait
    mem_access = 1'b1;
    toSample();
    checkOut("midDw", FULL_STALL, 1'b0, 1'b0, 1'b0);
    nextCycle();
    RST = 1'b1;
    toSample();
    checkOut("midRst", FULL_STALL, 1'b0, 1'b1, 1'b1);
    nextCycle();
    idle();
    toSample();
    checkOut("midPost", NO_STALL, 1'b1, 1'b0, 1'b0);
    check("midPost.stall_cnt", stall_cnt, 32'd0);
    nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
